// File: rtl/dccm_ctrl_pkg.sv
// Shared types and constants for the DCCM SRAM arbiter.
// Tag ids are sized for the largest supported requester count.
package dccm_ctrl_pkg;

   localparam int unsigned DefaultAw = 10;
   localparam int unsigned Depth     = 2 ** DefaultAw;
   localparam int unsigned MaxReq    = 4;
   localparam int unsigned IdW       = $clog2(MaxReq);

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   typedef struct packed {
      logic           valid;
      logic [IdW-1:0] id;
   } rsp_tag_t;

endpackage

// File: rtl/dccm_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above
// the pointer, wrapping modulo N.
module rr_arbiter #(
   parameter  int unsigned N    = 2,
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o
);

   logic            found;
   logic [IdxW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned off = 0; off < N; off++) begin
         cand = IdxW'((32'(ptr_i) + off) % N);
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            gnt_o[cand]  = 1'b1;
            idx_o        = cand;
         end
      end
   end

endmodule

// File: rtl/dccm_arbiter.sv
// Round-robin front end for the single-port DCCM SRAM, with optional
// zero-fill after reset and 1-cycle read-response routing.
module dccm_arbiter
   import dccm_ctrl_pkg::*;
#(
   parameter int unsigned NReq    = 2,
   parameter int unsigned Aw      = 10,
   parameter int unsigned Dw      = 32,
   parameter bit          MemInit = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NReq-1:0]           req_i,
   input  logic [NReq-1:0]           we_i,
   input  logic [NReq-1:0][Aw-1:0]   addr_i,
   input  logic [NReq-1:0][Dw-1:0]   wdata_i,
   input  logic [NReq-1:0][Dw/8-1:0] be_i,
   output logic [NReq-1:0]           gnt_o,
   output logic [NReq-1:0]           rvalid_o,
   output logic [Dw-1:0]             rdata_o,
   output logic                      init_done_o,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [Aw-1:0]             mem_addr_o,
   output logic [Dw-1:0]             mem_wdata_o,
   output logic [Dw/8-1:0]           mem_be_o,
   input  logic [Dw-1:0]             mem_rdata_i
);

   localparam int unsigned PtrW = $clog2(NReq);

   state_e          state_q;
   logic [Aw-1:0]   cnt_q;
   logic [PtrW-1:0] ptr_q, ptr_d;
   rsp_tag_t        tag_q, tag_d;
   logic [Dw-1:0]   rdata_q;

   logic [NReq-1:0] arb_gnt;
   logic [PtrW-1:0] arb_idx;
   logic            any_req;
   logic            in_init;
   logic            in_ready;

   // Gating with rst_ni keeps the SRAM idle while reset is held, even
   // though the state register already sits in INIT.
   assign in_init     = rst_ni && (state_q == INIT);
   assign in_ready    = rst_ni && (state_q == READY);
   assign any_req     = |req_i;
   assign init_done_o = (state_q == READY);

   rr_arbiter #(.N(NReq)) u_rr (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   always_comb begin
      gnt_o       = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (in_init) begin
         mem_req_o  = 1'b1;
         mem_we_o   = 1'b1;
         mem_addr_o = cnt_q;
         mem_be_o   = '1;
      end else if (in_ready) begin
         gnt_o       = arb_gnt;
         mem_req_o   = any_req;
         mem_we_o    = any_req & we_i[arb_idx];
         mem_addr_o  = addr_i[arb_idx];
         mem_wdata_o = wdata_i[arb_idx];
         mem_be_o    = be_i[arb_idx];
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (in_ready && any_req) begin
         ptr_d = (arb_idx == PtrW'(NReq - 1)) ? '0 : arb_idx + PtrW'(1);
      end
      tag_d.valid = in_ready & any_req & ~we_i[arb_idx];
      tag_d.id    = IdW'(arb_idx);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= MemInit ? INIT : READY;
         cnt_q   <= '0;
         ptr_q   <= '0;
         tag_q   <= '0;
         rdata_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         tag_q <= tag_d;
         if (tag_q.valid) begin
            rdata_q <= mem_rdata_i;
         end
         if (state_q == INIT) begin
            cnt_q <= cnt_q + Aw'(1);
            if (&cnt_q) begin
               state_q <= READY;
            end
         end
      end
   end

   // Live SRAM data while a response is due, otherwise the last response.
   assign rdata_o = tag_q.valid ? mem_rdata_i : rdata_q;

   for (genvar gi = 0; gi < NReq; gi++) begin : g_rvalid
      assign rvalid_o[gi] = tag_q.valid && (tag_q.id == IdW'(gi));
   end

endmodule

// File: tb/tb_dccm_arbiter.sv
// Self-checking bench for dccm_arbiter: SRAM model, behavioural reference
// model compared every cycle, plus directed literal checks.
module tb_dccm_arbiter;

   localparam int NReq  = 2;
   localparam int Aw    = 10;
   localparam int Dw    = 32;
   localparam int Bw    = Dw / 8;
   localparam int Depth = 1 << Aw;

   logic                    clk_i = 1'b0;
   logic                    rst_ni;
   logic [NReq-1:0]         req_i, we_i;
   logic [NReq-1:0][Aw-1:0] addr_i;
   logic [NReq-1:0][Dw-1:0] wdata_i;
   logic [NReq-1:0][Bw-1:0] be_i;
   logic [NReq-1:0]         gnt_o, rvalid_o;
   logic [Dw-1:0]           rdata_o;
   logic                    init_done_o;
   logic                    mem_req_o, mem_we_o;
   logic [Aw-1:0]           mem_addr_o;
   logic [Dw-1:0]           mem_wdata_o;
   logic [Bw-1:0]           mem_be_o;
   logic [Dw-1:0]           mem_rdata_i;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk_i = ~clk_i;

   dccm_arbiter #(.NReq(NReq), .Aw(Aw), .Dw(Dw), .MemInit(1'b1)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .be_i        (be_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .init_done_o (init_done_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_be_o    (mem_be_o),
      .mem_rdata_i (mem_rdata_i)
   );

   // SRAM model: byte-masked write, registered read, garbage when not reading.
   logic [Dw-1:0] sram [Depth];
   always @(posedge clk_i) begin
      if (mem_req_o && mem_we_o) begin
         for (int b = 0; b < Bw; b++)
            if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         mem_rdata_i <= $urandom;
      end else if (mem_req_o) begin
         mem_rdata_i <= sram[mem_addr_o];
      end else begin
         mem_rdata_i <= $urandom;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference model state
   int            init_left;
   int            ptr;
   bit            pend_v;
   int            pend_id;
   logic [Dw-1:0] pend_data;
   logic [Dw-1:0] last_rdata;
   logic [Dw-1:0] ref_mem [Depth];

   task automatic model_reset();
      init_left  = Depth;
      ptr        = 0;
      pend_v     = 1'b0;
      pend_id    = 0;
      last_rdata = '0;
   endtask

   task automatic model_step();
      int k;
      int a;
      logic [NReq-1:0] ev;
      chk("init_done", 32'(init_done_o), 32'(init_left == 0));
      if (pend_v) last_rdata = pend_data;
      ev = pend_v ? NReq'(1 << pend_id) : '0;
      chk("rvalid", 32'(rvalid_o), 32'(ev));
      chk("rdata", rdata_o, last_rdata);
      pend_v = 1'b0;
      if (init_left > 0) begin
         a = Depth - init_left;
         chk("init_gnt", 32'(gnt_o), 0);
         chk("init_req", 32'(mem_req_o), 1);
         chk("init_we", 32'(mem_we_o), 1);
         chk("init_addr", 32'(mem_addr_o), a);
         chk("init_wdata", mem_wdata_o, 0);
         chk("init_be", 32'(mem_be_o), 32'hF);
         ref_mem[a] = '0;
         init_left--;
      end else begin
         k = -1;
         for (int off = 0; off < NReq; off++)
            if (k < 0 && req_i[(ptr + off) % NReq]) k = (ptr + off) % NReq;
         chk("gnt", 32'(gnt_o), (k < 0) ? 0 : (1 << k));
         chk("mem_req", 32'(mem_req_o), 32'(k >= 0));
         if (k >= 0) begin
            chk("mem_we", 32'(mem_we_o), 32'(we_i[k]));
            chk("mem_addr", 32'(mem_addr_o), 32'(addr_i[k]));
            chk("mem_wdata", mem_wdata_o, wdata_i[k]);
            chk("mem_be", 32'(mem_be_o), 32'(be_i[k]));
            if (we_i[k]) begin
               for (int b = 0; b < Bw; b++)
                  if (be_i[k][b]) ref_mem[addr_i[k]][8*b +: 8] = wdata_i[k][8*b +: 8];
            end else begin
               pend_v    = 1'b1;
               pend_id   = k;
               pend_data = ref_mem[addr_i[k]];
            end
            ptr = (k + 1) % NReq;
            $display("txn t=%0t req%0d %s addr=%0d wdata=%h be=%b", $time, k,
                     we_i[k] ? "WR" : "RD", addr_i[k], wdata_i[k], be_i[k]);
         end
      end
   endtask

   always @(negedge clk_i) begin
      if (!rst_ni) model_reset();
      else model_step();
   end

   task automatic wait_init(output int n);
      n = 0;
      while (n < 2000) begin
         @(negedge clk_i);
         if (init_done_o) break;
         n++;
      end
   endtask

   task automatic issue(input int k, input bit w, input int a, input logic [31:0] d,
                        input logic [3:0] be);
      req_i      = '0;
      req_i[k]   = 1'b1;
      we_i[k]    = w;
      addr_i[k]  = Aw'(a);
      wdata_i[k] = d;
      be_i[k]    = be;
      @(posedge clk_i); #1;
      req_i = '0;
   endtask

   int              n;
   logic [7:0]      seq;
   logic [NReq-1:0] g;

   initial begin
      rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
      repeat (2) @(posedge clk_i); #1;
      chk("rst_gnt", 32'(gnt_o), 0);
      chk("rst_rvalid", 32'(rvalid_o), 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_mem_req", 32'(mem_req_o), 0);
      chk("rst_mem_we", 32'(mem_we_o), 0);
      chk("rst_init_done", 32'(init_done_o), 0);

      // Both requesters hold reads throughout INIT.
      req_i = 2'b11; addr_i[0] = 10'd1; addr_i[1] = 10'd2;
      #1 rst_ni = 1'b1;
      wait_init(n);
      chk("init_len", n, 1024);
      chk("first_gnt", 32'(gnt_o), 32'b01);
      seq[7:6] = gnt_o;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk_i);
         seq[7-2*i -: 2] = gnt_o;
      end
      chk("alternate", 32'(seq), 32'b01_10_01_10);
      @(posedge clk_i); #1 req_i = '0;

      // Partial byte write then read-back.
      issue(0, 1'b1, 5, 32'h11223344, 4'hF);
      issue(0, 1'b1, 5, 32'hDEADBEEF, 4'b0011);
      issue(0, 1'b0, 5, 32'h0, 4'h0);
      chk("be_rvalid", 32'(rvalid_o), 32'b01);
      chk("be_rdata", rdata_o, 32'h1122BEEF);

      // Back-to-back reads from different requesters.
      issue(1, 1'b1, 7, 32'hA7A70007, 4'hF);
      issue(0, 1'b1, 8, 32'hB8B80008, 4'hF);
      issue(1, 1'b0, 7, 32'h0, 4'hF);
      req_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 10'd8;
      chk("rd7_rvalid", 32'(rvalid_o), 32'b10);
      chk("rd7_rdata", rdata_o, 32'hA7A70007);
      @(posedge clk_i); #1 req_i = '0;
      chk("rd8_rvalid", 32'(rvalid_o), 32'b01);
      chk("rd8_rdata", rdata_o, 32'hB8B80008);

      // Randomized traffic; requests held until granted.
      for (int c = 0; c < 600; c++) begin
         @(negedge clk_i); g = gnt_o;
         @(posedge clk_i); #1;
         for (int k = 0; k < NReq; k++) begin
            if (g[k]) req_i[k] = 1'b0;
            if (!req_i[k] && $urandom_range(0, 2) != 0) begin
               req_i[k]   = 1'b1;
               we_i[k]    = 1'($urandom_range(0, 1));
               addr_i[k]  = Aw'($urandom_range(0, 15));
               wdata_i[k] = $urandom;
               be_i[k]    = 4'($urandom_range(0, 15));
            end
         end
      end
      @(negedge clk_i);
      @(posedge clk_i); #1 req_i = '0;

      // Reset in the middle of INIT.
      #1 rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #2 rst_ni = 1'b1;
      req_i = 2'b01; we_i[0] = 1'b0; addr_i[0] = 10'd1;
      n = 0;
      while (mem_addr_o != 10'd300 && n < 2000) begin
         @(posedge clk_i); #1; n++;
      end
      chk("init_addr300", 32'(mem_addr_o), 300);
      #1 rst_ni = 1'b0; #1;
      chk("mid_mem_req", 32'(mem_req_o), 0);
      chk("mid_mem_we", 32'(mem_we_o), 0);
      chk("mid_gnt", 32'(gnt_o), 0);
      chk("mid_init_done", 32'(init_done_o), 0);
      repeat (2) @(posedge clk_i);
      #2 rst_ni = 1'b1;
      wait_init(n);
      chk("reinit_len", n, 1024);
      chk("reinit_gnt", 32'(gnt_o), 32'b01);

      // Read granted, then reset before the capturing edge.
      @(posedge clk_i); #1 addr_i[0] = 10'd5;
      @(negedge clk_i);
      chk("rr_gnt", 32'(gnt_o), 32'b01);
      #1 rst_ni = 1'b0; req_i = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         chk("rr_drop", 32'(rvalid_o), 0);
      end
      #1 rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         chk("rr_drop_post", 32'(rvalid_o), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
